// File: rtl/pn_frame_tx.sv
// Serial test-pattern framer: a sync word followed by a PN7 payload, one bit
// per rising edge of a sys_clk-synchronous divided bit clock.
module pn_frame_tx #(
  parameter int                  SYNC_LEN    = 7,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 7'b1110010,
  parameter int                  PAYLOAD_LEN = 24,
  parameter logic [6:0]          PN_SEED     = 7'h7F,
  parameter int                  FCNT_W      = 8
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              bit_clk,
  input  logic              en,
  output logic              data_out,
  output logic              bit_stb,
  output logic              frame_start,
  output logic              in_payload,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int SW = $clog2(SYNC_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        idx_reg, idx_next;
  logic [6:0]        lfsr_reg, lfsr_next;
  logic              data_reg, data_next;
  logic              stb_reg, stb_next;
  logic              fs_reg, fs_next;
  logic              ip_reg, ip_next;
  logic [FCNT_W-1:0] cnt_reg, cnt_next;
  logic              bclk_d_reg;
  logic              tick;
  logic [7:0]        sync_sel;
  logic [6:0]        lfsr_adv;

  // bit_clk is generated by flops on sys_clk, so a single delay stage suffices.
  assign tick     = bit_clk & ~bclk_d_reg;
  assign sync_sel = 8'(SYNC_LEN - 1) - idx_reg;
  // An all-zero state would lock up the LFSR; recover by reloading the seed.
  assign lfsr_adv = (lfsr_reg == 7'd0) ? PN_SEED : {lfsr_reg[5:0], lfsr_reg[6] ^ lfsr_reg[5]};

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      idx_reg    <= 8'd0;
      lfsr_reg   <= PN_SEED;
      data_reg   <= 1'b0;
      stb_reg    <= 1'b0;
      fs_reg     <= 1'b0;
      ip_reg     <= 1'b0;
      cnt_reg    <= '0;
      bclk_d_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      lfsr_reg   <= lfsr_next;
      data_reg   <= data_next;
      stb_reg    <= stb_next;
      fs_reg     <= fs_next;
      ip_reg     <= ip_next;
      cnt_reg    <= cnt_next;
      bclk_d_reg <= bit_clk;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    lfsr_next  = lfsr_reg;
    data_next  = data_reg;
    stb_next   = 1'b0;
    fs_next    = 1'b0;
    ip_next    = ip_reg;
    cnt_next   = cnt_reg;
    if (tick) begin
      case (state_reg)
        IDLE: begin
          if (en) begin
            state_next = SYNC;
            data_next  = SYNC_WORD[SYNC_LEN-1];
            fs_next    = 1'b1;
            stb_next   = 1'b1;
            ip_next    = 1'b0;
            idx_next   = 8'd1;
          end
        end
        SYNC: begin
          stb_next = 1'b1;
          if (idx_reg == 8'(SYNC_LEN)) begin
            state_next = PAYLOAD;
            data_next  = lfsr_reg[6];
            lfsr_next  = lfsr_adv;
            ip_next    = 1'b1;
            idx_next   = 8'd1;
          end else begin
            data_next = SYNC_WORD[sync_sel[SW-1:0]];
            idx_next  = idx_reg + 8'd1;
          end
        end
        PAYLOAD: begin
          if (idx_reg == 8'(PAYLOAD_LEN)) begin
            cnt_next = cnt_reg + 1'b1;
            // Back-to-back frames: the closing tick already carries the next sync bit.
            if (en) begin
              state_next = SYNC;
              data_next  = SYNC_WORD[SYNC_LEN-1];
              fs_next    = 1'b1;
              stb_next   = 1'b1;
              ip_next    = 1'b0;
              idx_next   = 8'd1;
            end else begin
              state_next = IDLE;
              data_next  = 1'b0;
              ip_next    = 1'b0;
              idx_next   = 8'd0;
            end
          end else begin
            stb_next  = 1'b1;
            data_next = lfsr_reg[6];
            lfsr_next = lfsr_adv;
            idx_next  = idx_reg + 8'd1;
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = 8'd0;
          data_next  = 1'b0;
          ip_next    = 1'b0;
        end
      endcase
    end
  end

  assign data_out    = data_reg;
  assign bit_stb     = stb_reg;
  assign frame_start = fs_reg;
  assign in_payload  = ip_reg;
  assign frame_cnt   = cnt_reg;

endmodule

// File: tb/tb_pn_frame_tx.sv
// Bench for pn_frame_tx: a frame-position model predicts every output each
// cycle; directed sequences pin bit patterns, cadence, counts and reset.
module tb_pn_frame_tx;

  localparam int             SYNC_LEN    = 7;
  localparam logic [6:0]     SYNC_WORD   = 7'b1110010;
  localparam int             PAYLOAD_LEN = 24;
  localparam int             FRAME       = SYNC_LEN + PAYLOAD_LEN;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b0;
  logic       bit_clk = 1'b0;
  logic       en      = 1'b0;
  logic       data_out1, bit_stb1, frame_start1, in_payload1;
  logic [7:0] frame_cnt1;
  logic       data_out2, bit_stb2, frame_start2, in_payload2;
  logic [1:0] frame_cnt2;

  int         n_cmp = 0;
  int         n_bad = 0;

  pn_frame_tx u_dut (
    .sys_clk(sys_clk), .reset(reset), .bit_clk(bit_clk), .en(en),
    .data_out(data_out1), .bit_stb(bit_stb1), .frame_start(frame_start1),
    .in_payload(in_payload1), .frame_cnt(frame_cnt1)
  );

  pn_frame_tx #(.FCNT_W(2)) u_dut2 (
    .sys_clk(sys_clk), .reset(reset), .bit_clk(bit_clk), .en(en),
    .data_out(data_out2), .bit_stb(bit_stb2), .frame_start(frame_start2),
    .in_payload(in_payload2), .frame_cnt(frame_cnt2)
  );

  always #5 sys_clk = ~sys_clk;

  // Divided bit clock as the generator produces it: toggles every bc_half cycles, 0 = frozen.
  int bc_half = 32;
  int bc_cnt  = 0;
  always @(posedge sys_clk) begin
    if (bc_half != 0) begin
      if (bc_cnt >= bc_half - 1) begin
        bc_cnt  <= 0;
        bit_clk <= ~bit_clk;
      end else begin
        bc_cnt <= bc_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference PN7 stream and first frame, built in the main initial block.
  bit pn_seq [0:126];
  bit ref_frame [0:FRAME-1];

  // Model: position within the frame plus an index into the PN stream.
  int         m_pos = 0;
  int         m_pn  = 0;
  logic [7:0] m_cnt = 8'd0;
  logic       m_prev = 1'b0;
  logic       m_d = 1'b0, m_stb = 1'b0, m_fs = 1'b0, m_ip = 1'b0;

  always @(posedge sys_clk or negedge reset) begin : model
    int         p;
    int         q;
    logic [7:0] c;
    logic       d, st, fs, ip;
    if (!reset) begin
      m_pos  <= 0;
      m_pn   <= 0;
      m_cnt  <= 8'd0;
      m_prev <= 1'b0;
      m_d    <= 1'b0;
      m_stb  <= 1'b0;
      m_fs   <= 1'b0;
      m_ip   <= 1'b0;
    end else begin
      p = m_pos; q = m_pn; c = m_cnt; d = m_d; ip = m_ip; st = 1'b0; fs = 1'b0;
      if (bit_clk && !m_prev) begin
        if (p == FRAME) begin
          c = c + 8'd1;
          p = 0;
        end
        if (p == 0) begin
          d = 1'b0; ip = 1'b0;
          if (en) begin
            p = 1; st = 1'b1; fs = 1'b1;
            d = SYNC_WORD[SYNC_LEN-1];
          end
        end else begin
          p = p + 1; st = 1'b1;
          if (p <= SYNC_LEN) begin
            d = SYNC_WORD[SYNC_LEN-p]; ip = 1'b0;
          end else begin
            d = pn_seq[q]; q = (q + 1) % 127; ip = 1'b1;
          end
        end
      end
      m_prev <= bit_clk;
      m_pos  <= p;
      m_pn   <= q;
      m_cnt  <= c;
      m_d    <= d;
      m_stb  <= st;
      m_fs   <= fs;
      m_ip   <= ip;
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge sys_clk) begin
    chk("outputs_fcnt8", {data_out1, bit_stb1, frame_start1, in_payload1, frame_cnt1},
        {m_d, m_stb, m_fs, m_ip, m_cnt});
    chk("outputs_fcnt2", {data_out2, bit_stb2, frame_start2, in_payload2, frame_cnt2},
        {m_d, m_stb, m_fs, m_ip, m_cnt[1:0]});
  end

  // Strobe log of the 8-bit-counter instance.
  int cyc     = 0;
  int stb_cnt = 0;
  bit ev_d [$];
  bit ev_fs [$];
  bit ev_ip [$];
  int ev_cyc [$];
  always @(negedge sys_clk) begin
    cyc <= cyc + 1;
    if (reset && bit_stb1) begin
      stb_cnt <= stb_cnt + 1;
      ev_d.push_back(data_out1);
      ev_fs.push_back(frame_start1);
      ev_ip.push_back(in_payload1);
      ev_cyc.push_back(cyc);
    end
  end

  task automatic wait_stb(input int target, input int budget, input string name);
    int n = 0;
    while (stb_cnt < target && n < budget) begin
      @(posedge sys_clk);
      n++;
    end
    chk(name, longint'(stb_cnt >= target), 1);
    @(negedge sys_clk);
  endtask

  task automatic chk_frame(input int base, input string name);
    int bad = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (base + k >= ev_d.size()) bad++;
      else if (ev_d[base+k] != ref_frame[k] || ev_fs[base+k] != (k == 0) ||
               ev_ip[base+k] != (k >= SYNC_LEN)) bad++;
    end
    chk(name, bad, 0);
  endtask

  initial begin : main
    logic [6:0]  s;
    logic [14:0] head;
    int          base, bad, nfs, ones, per;
    bit          pay [$];

    s = 7'h7F; ones = 0; per = 0;
    for (int i = 0; i < 127; i++) begin
      pn_seq[i] = s[6];
      ones += int'(s[6]);
      s = {s[5:0], s[6] ^ s[5]};
      if (s == 7'h7F && per == 0) per = i + 1;
    end
    for (int k = 0; k < FRAME; k++)
      ref_frame[k] = (k < SYNC_LEN) ? SYNC_WORD[SYNC_LEN-1-k] : pn_seq[k-SYNC_LEN];
    chk("pn_period", per, 127);
    chk("pn_ones", ones, 64);

    // 1: reset with clk_32 running, then idle with en low
    repeat (20) @(negedge sys_clk);
    reset = 1'b1;
    repeat (1000) @(negedge sys_clk);
    chk("idle_no_stb", stb_cnt, 0);

    // 2/3: first frame then 20 back-to-back frames
    base = stb_cnt;
    en = 1'b1;
    wait_stb(base + 20*FRAME + 1, 45000, "run20_timeout");
    for (int k = 0; k < 15; k++) head[14-k] = ev_d[base+k];
    chk("first15_bits", head, 15'b111001011111110);
    chk_frame(base, "frame1_bits");
    chk("bit_period64", ev_cyc[base+1] - ev_cyc[base], 64);
    chk("bit_period64b", ev_cyc[base+30] - ev_cyc[base+29], 64);
    nfs = 0; bad = 0;
    for (int i = 0; i <= 20*FRAME; i++) begin
      if (ev_fs[base+i]) begin
        nfs++;
        if (i % FRAME != 0) bad++;
      end
      if (ev_ip[base+i]) pay.push_back(ev_d[base+i]);
    end
    chk("frame_start_count", nfs, 21);
    chk("frame_start_spacing", bad, 0);
    bad = 0;
    for (int i = 0; i < pay.size(); i++) begin
      if (pay[i] != pn_seq[i % 127]) bad++;
      if (i + 127 < pay.size() && pay[i] != pay[i+127]) bad++;
    end
    chk("payload_len", pay.size(), 20*PAYLOAD_LEN);
    chk("payload_stream", bad, 0);
    chk("frame_cnt_20", frame_cnt1, 20);

    // 4: drop en right after payload bit 10 of frame 21
    base = stb_cnt - 1;
    wait_stb(base + SYNC_LEN + 10, 2000, "en_drop_timeout");
    en = 1'b0;
    repeat (2500) @(negedge sys_clk);
    chk("en_drop_bits", stb_cnt, base + FRAME);
    chk("en_drop_last_payload", ev_ip[base+FRAME-1], 1);
    chk("en_drop_frame_cnt", frame_cnt1, 21);
    chk("en_drop_data", data_out1, 0);
    chk("en_drop_in_payload", in_payload1, 0);

    // 5: async reset after payload bit 5
    base = stb_cnt;
    en = 1'b1;
    wait_stb(base + SYNC_LEN + 5, 2000, "pre_reset_timeout");
    chk("pre_reset_data", data_out1, 1);
    @(posedge sys_clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_data", data_out1, 0);
    chk("async_rst_inpay", in_payload1, 0);
    chk("async_rst_cnt", frame_cnt1, 0);
    repeat (3) @(negedge sys_clk);
    reset = 1'b1;
    base = stb_cnt;
    wait_stb(base + FRAME + 1, 3000, "post_reset_timeout");
    chk_frame(base, "post_reset_frame");
    chk("post_reset_cnt", frame_cnt1, 1);

    // 6: clk_2, four frames, 2-bit counter wraps to 0
    reset = 1'b0;
    bc_half = 1;
    repeat (4) @(negedge sys_clk);
    reset = 1'b1;
    base = stb_cnt;
    wait_stb(base + 4*FRAME + 1, 2000, "fast_timeout");
    chk_frame(base, "fast_frame");
    bad = 0;
    for (int i = 1; i <= 4*FRAME; i++)
      if (ev_cyc[base+i] - ev_cyc[base+i-1] != 2) bad++;
    chk("fast_period2", bad, 0);
    chk("fast_cnt8", frame_cnt1, 4);
    chk("fast_cnt2_wrap", frame_cnt2, 0);

    // bit_clk frozen: no further strobes
    bc_half = 0;
    repeat (4) @(negedge sys_clk);
    base = stb_cnt;
    repeat (200) @(negedge sys_clk);
    chk("frozen_no_stb", stb_cnt, base);
    chk("frozen_stb_low", bit_stb1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pn_frame_tx.md
Name: pn_frame_tx

Overview:
- Baseband test-pattern framer running on sys_clk, directly downstream of the clock generator.
- Takes one of the generator's divided clocks (clk_2/clk_4/clk_32/clk_128) as a bit-rate reference and detects its rising edge.
- On each bit tick it emits one serial bit: a fixed sync word followed by a PN7 pseudo-random payload.
- Frame, tick and count outputs drive the channel/modulator experiments.

Parameters:
SYNC_LEN, 7, sync word length in bits (2..16)
SYNC_WORD, 7'b1110010, sync pattern (Barker-7), transmitted MSB first
PAYLOAD_LEN, 24, payload bits per frame (1..255)
PN_SEED, 7'h7F, LFSR reset value; must be non-zero
FCNT_W, 8, frame counter width

Ports:
sys_clk  input  1  system clock; all logic on its rising edge
reset  input  1  asynchronous, active-low reset
bit_clk  input  1  divided clock from the clock generator, sys_clk-synchronous; period ≥2 sys_clk cycles
en  input  1  transmit enable; sampled only at tick/frame boundaries
data_out  output  1  serial bit, held between ticks
bit_stb  output  1  one-cycle pulse: data_out updated this cycle
frame_start  output  1  one-cycle pulse coincident with bit_stb for the first sync bit
in_payload  output  1  high while data_out carries a payload bit
frame_cnt  output  FCNT_W  completed-frame count, wraps to 0

Behaviour:
- Reset (reset=0, async): data_out=0, bit_stb=0, frame_start=0, in_payload=0, frame_cnt=0, LFSR=PN_SEED, bclk_d=0, FSM=IDLE, bit index=0.
- Tick detect: bclk_d <= bit_clk every cycle. tick = bit_clk & ~bclk_d (combinational).
  - bit_clk needs no synchronizer because it comes from the generator's flops.
  - Tick in cycle N → outputs updated at the end of N; bit_stb (and frame_start if applicable) high only during cycle N+1. Latency is 1 cycle.
- FSM (all transitions only on tick):
  - IDLE: data_out=0, in_payload=0.
    - tick & en → SYNC: emit SYNC_WORD[SYNC_LEN-1], frame_start=1, idx=1.
    - tick & !en → stay in IDLE, no bit_stb.
  - SYNC: emit SYNC_WORD[SYNC_LEN-1-idx], idx++.
    - After the final sync bit has been emitted, the next tick → PAYLOAD, emitting the first PN bit, in_payload=1, idx=1.
  - PAYLOAD: each tick emits LFSR[6] and advances the LFSR.
    - After PAYLOAD_LEN bits, the next tick ends the frame: frame_cnt++ (wrap at 2^FCNT_W).
    - If en=1: restart SYNC on that same tick (first sync bit, frame_start=1). Frames are back-to-back with no gap bit.
    - If en=0: go to IDLE, data_out=0, no bit_stb.
- LFSR: 7-bit, polynomial x^7+x^6+1, period 127.
  - Output bit = s[6]; next state = {s[5:0], s[6]^s[5]}.
  - Advances only when a payload bit is emitted.
  - Runs continuously across frames; not reseeded per frame.
  - If the state is ever all-zero, load PN_SEED on the next advance.
- en deasserted mid-frame: the current frame completes in full, then the FSM goes to IDLE.
- en asserted mid-IDLE between ticks: no effect until the next tick.
- Reset mid-frame: immediate return to reset values. The partial frame is not counted, and the LFSR restarts at PN_SEED.
- bit_clk held constant: no ticks, all outputs hold, bit_stb stays 0.
- Outputs are registered, no combinational path from inputs.

Test Plan:
1. Reset and idle: assert reset with bit_clk=clk_32 running and en=0 → all outputs 0, no bit_stb over 1000 cycles.
2. First frame: en=1, bit_clk=clk_32 (rises every 64 cycles).
   - bit_stb every 64 cycles, each exactly 1 cycle wide, one cycle after the bit_clk rise.
   - frame_start on bit 1 only.
   - Bits 1–7 = 1,1,1,0,0,1,0.
   - Payload bits 1–8 = 1,1,1,1,1,1,1,0 with in_payload=1.
   - frame_cnt=1 on the tick after bit 31.
3. Continuous run: en held high for 20 frames → frame_start every 31 ticks with no gap.
   - Payload stream concatenated across frames has period 127 and matches the reference LFSR model.
   - frame_cnt=20.
4. en drop: deassert en at payload bit 10 → remaining 14 payload bits still sent, frame_cnt increments, then no further bit_stb and data_out=0.
5. Async reset mid-payload (bit 5): outputs clear immediately without a clock edge.
   - After release with en=1, the next frame is byte-identical to test 2 and frame_cnt restarts from 0.
6. Fastest rate: bit_clk=clk_2 (rises every 2 cycles) → bit_stb every 2 cycles, bit sequence identical to test 2.
   - With FCNT_W=2, frame_cnt wraps 3→0 on frame 4.
